// File: rtl/gcd_arb_pkg.sv
// gcd_arb_pkg
//   Shared definitions for the GCD job arbiter: FSM state encoding and the
//   default sizing used by gcd_job_arbiter when no overrides are given.
package gcd_arb_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_CLEAR = 3'd4
    } arb_state_t;

endpackage

// File: rtl/gcd_job_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Searches req cyclically starting at
//   ptr+1 and returns the first set index, so the requester just served
//   (ptr) has the lowest priority on the next pick.
// Ports
//   req        in   N_REQ   request vector
//   ptr        in   IW      index of the requester served last
//   winner     out  IW      selected index (meaningful only when any_valid)
//   any_valid  out  1       at least one request is set
module rr_pick
    import gcd_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IW    = $clog2(DEF_N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    winner,
    output logic             any_valid
);

    logic [IW-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest set request
    // after ptr is the last assignment and therefore wins.
    always_comb begin
        winner    = ptr;
        idx       = '0;
        any_valid = |req;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % N_REQ);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/gcd_job_arbiter.sv
// gcd_job_arbiter
//   Shares one GCD engine among N_REQ requesters. A round-robin pick in IDLE
//   latches the winner's operands; jobs with a zero operand are answered
//   directly (gcd(0,x) = x), all others start the engine, wait for done (or
//   abort after TIMEOUT wait cycles), return the result with a one-cycle ack
//   and finally pulse eng_clear to put the engine back to idle.
// Ports
//   clock       in   1             rising-edge system clock
//   reset       in   1             asynchronous active-high reset
//   req         in   N_REQ         level job requests, held until ack
//   a_in        in   N_REQ*WIDTH   operand A per requester (slice i)
//   b_in        in   N_REQ*WIDTH   operand B per requester (slice i)
//   ack         out  N_REQ         one-hot completion pulse
//   result      out  WIDTH         GCD result, valid with ack, then held
//   err         out  1             job aborted on timeout, valid with ack
//   busy        out  1             arbiter is not idle
//   grant_id    out  IW            requester currently / last served
//   eng_a       out  WIDTH         registered operand A to the engine
//   eng_b       out  WIDTH         registered operand B to the engine
//   eng_start   out  1             one-cycle engine start
//   eng_clear   out  1             one-cycle engine return-to-idle
//   eng_done    in   1             engine finished (level until eng_clear)
//   eng_result  in   WIDTH         engine result, valid while eng_done
module gcd_job_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int IW     = $clog2(N_REQ),
    localparam int CW     = $clog2(TIMEOUT + 1)
)(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       ack,
    output logic [WIDTH-1:0]       result,
    output logic                   err,
    output logic                   busy,
    output logic [IW-1:0]          grant_id,
    output logic [WIDTH-1:0]       eng_a,
    output logic [WIDTH-1:0]       eng_b,
    output logic                   eng_start,
    output logic                   eng_clear,
    input  logic                   eng_done,
    input  logic [WIDTH-1:0]       eng_result
);

    arb_state_t       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    winner;
    logic             any_req;
    logic [CW-1:0]    count;
    logic             engine_used;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req       (req),
        .ptr       (ptr),
        .winner    (winner),
        .any_valid (any_req)
    );

    assign win_a = a_in[int'(winner)*WIDTH +: WIDTH];
    assign win_b = b_in[int'(winner)*WIDTH +: WIDTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ack         <= '0;
            result      <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= '0;
            eng_a       <= '0;
            eng_b       <= '0;
            eng_start   <= 1'b0;
            eng_clear   <= 1'b0;
            count       <= '0;
            ptr         <= IW'(N_REQ - 1);
            engine_used <= 1'b0;
        end else begin
            ack       <= '0;
            eng_start <= 1'b0;
            eng_clear <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A bypass job returns to IDLE while its ack is still on
                    // the wire; the requester may hold req through that cycle,
                    // so no new grant is made until the ack has gone.
                    if (any_req && ack == '0) begin
                        grant_id <= winner;
                        ptr      <= winner;
                        eng_a    <= win_a;
                        eng_b    <= win_b;
                        busy     <= 1'b1;
                        if (win_a == '0 || win_b == '0) begin
                            result      <= win_a | win_b;
                            err         <= 1'b0;
                            engine_used <= 1'b0;
                            state       <= ST_RESP;
                        end else begin
                            eng_start   <= 1'b1;
                            engine_used <= 1'b1;
                            state       <= ST_START;
                        end
                    end
                end
                ST_START: begin
                    count <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        result <= eng_result;
                        err    <= 1'b0;
                        state  <= ST_RESP;
                    end else begin
                        count <= count + 1'b1;
                        // Abort on the wait cycle that brings count to TIMEOUT.
                        if (count == CW'(TIMEOUT - 1)) begin
                            result <= '0;
                            err    <= 1'b1;
                            state  <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    ack <= {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
                    if (engine_used) begin
                        eng_clear <= 1'b1;
                        state     <= ST_CLEAR;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// tb_gcd_job_arbiter
//   Bench for gcd_job_arbiter with a behavioural GCD engine and a job-timeline
//   reference model. The model tracks each job by the number of clock edges
//   since its grant and derives every registered output from that age.
module tb_gcd_job_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;
    localparam int IW = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] a_in  = '0;
    logic [N*W-1:0] b_in  = '0;
    logic [N-1:0]   ack;
    logic [W-1:0]   result;
    logic           err;
    logic           busy;
    logic [IW-1:0]  grant_id;
    logic [W-1:0]   eng_a;
    logic [W-1:0]   eng_b;
    logic           eng_start;
    logic           eng_clear;
    logic           eng_done   = 1'b0;
    logic [W-1:0]   eng_result = '0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    always #5 clock = ~clock;

    gcd_job_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .ack        (ack),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .grant_id   (grant_id),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_start  (eng_start),
        .eng_clear  (eng_clear),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    function automatic int gcd_f(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expired(input string name);
        total++;
        bad++;
        $display("FAIL %s wait budget expired at %0t", name, $time);
    endtask

    // ---------------- behavioural GCD engine ----------------
    int           eng_lat    = 5;
    bit           eng_never  = 0;
    bit           rand_hang  = 0;
    bit           glitch_en  = 0;
    bit           eng_act    = 0;
    bit           eng_fin    = 0;
    bit           eng_hang   = 0;
    int           eng_cnt    = 0;
    int           eng_starts = 0;
    logic [W-1:0] eng_res    = '0;

    always @(negedge clock or posedge reset) begin
        if (reset) begin
            eng_act    = 0;
            eng_fin    = 0;
            eng_done   = 1'b0;
            eng_result = '0;
        end else begin
            if (eng_clear) begin
                eng_act = 0;
                eng_fin = 0;
            end
            if (eng_start) begin
                eng_act  = 1;
                eng_fin  = 0;
                eng_cnt  = eng_lat;
                eng_hang = eng_never || (rand_hang && $urandom_range(0, 7) == 0);
                eng_res  = W'(gcd_f(int'(eng_a), int'(eng_b)));
                eng_starts++;
                // stale done during START must be ignored by the arbiter
                eng_done = glitch_en && ($urandom_range(0, 1) == 1);
            end else if (eng_act) begin
                if (!eng_fin && !eng_hang) begin
                    if (eng_cnt > 0) eng_cnt--;
                    if (eng_cnt == 0) eng_fin = 1;
                end
                eng_done = eng_fin;
            end else begin
                eng_done = glitch_en && ($urandom_range(0, 3) == 0);
            end
            eng_result = (eng_act && eng_fin) ? eng_res : W'($urandom);
        end
    end

    // ---------------- reference model ----------------
    int           m_ptr, m_t, m_fin_t, m_w, m_c;
    bit           m_on, m_fin, m_eng, m_found;
    int           m_a, m_b;
    logic [N-1:0] e_ack;
    logic [W-1:0] e_result, e_eng_a, e_eng_b;
    logic         e_err, e_busy, e_start, e_clear;
    logic [IW-1:0] e_grant;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ptr = N - 1; m_on = 0; m_fin = 0;
            e_ack = '0; e_result = '0; e_err = 0; e_busy = 0; e_grant = '0;
            e_eng_a = '0; e_eng_b = '0; e_start = 0; e_clear = 0;
        end else begin
            e_ack = '0; e_start = 0; e_clear = 0;
            if (m_on) begin
                m_t++;
                if (m_eng && !m_fin) begin
                    if (m_t >= 2 && eng_done) begin
                        m_fin = 1; m_fin_t = m_t;
                        e_result = W'(gcd_f(m_a, m_b)); e_err = 0;
                    end else if (m_t == 1 + TO) begin
                        m_fin = 1; m_fin_t = m_t;
                        e_result = '0; e_err = 1;
                    end
                end
                if (m_fin && m_t == m_fin_t + 1) begin
                    e_ack[m_w] = 1'b1;
                    e_clear = m_eng;
                    if (!m_eng) e_busy = 0;
                end
                if (m_fin && m_t == m_fin_t + 2) begin
                    e_busy = 0;
                    m_on = 0;
                end
            end else if (|req) begin
                m_found = 0;
                for (int k = 1; k <= N; k++) begin
                    m_c = (m_ptr + k) % N;
                    if (!m_found && req[m_c]) begin
                        m_w = m_c; m_found = 1;
                    end
                end
                m_ptr = m_w; m_on = 1; m_t = 0;
                m_a = int'(a_in[m_w*W +: W]);
                m_b = int'(b_in[m_w*W +: W]);
                e_grant = IW'(m_w); e_eng_a = W'(m_a); e_eng_b = W'(m_b); e_busy = 1;
                m_eng = (m_a != 0 && m_b != 0);
                if (m_eng) begin
                    m_fin = 0; e_start = 1;
                end else begin
                    m_fin = 1; m_fin_t = 0;
                    e_result = W'(m_a | m_b); e_err = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en && !reset) begin
            check("ack", 32'(ack), 32'(e_ack));
            check("result", 32'(result), 32'(e_result));
            check("err", 32'(err), 32'(e_err));
            check("busy", 32'(busy), 32'(e_busy));
            check("grant_id", 32'(grant_id), 32'(e_grant));
            check("eng_a", 32'(eng_a), 32'(e_eng_a));
            check("eng_b", 32'(eng_b), 32'(e_eng_b));
            check("eng_start", 32'(eng_start), 32'(e_start));
            check("eng_clear", 32'(eng_clear), 32'(e_clear));
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_ops(input int i, input int a, input int b);
        a_in[i*W +: W] = W'(a);
        b_in[i*W +: W] = W'(b);
    endtask

    task automatic wait_ack(input string name, input int limit, output int cyc);
        cyc = 0;
        while (ack == '0 && cyc < limit) begin
            @(negedge clock);
            cyc++;
        end
        if (ack == '0) expired(name);
    endtask

    task automatic wait_start(input string name, input int limit);
        int c;
        c = 0;
        while (eng_start !== 1'b1 && c < limit) begin
            @(negedge clock);
            c++;
        end
        if (eng_start !== 1'b1) expired(name);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
    endtask

    function automatic int rnd_op();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 0;
        if (r < 5) return $urandom_range(1, 15) * $urandom_range(1, 12);
        return $urandom_range(1, 255);
    endfunction

    bit [N-1:0] drop_next = '0;

    initial begin
        int cyc, s0;
        #1 reset = 1'b1;
        #13 reset = 1'b0;
        @(negedge clock);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_grant", 32'(grant_id), 32'd0);
        chk_en = 1;

        // single engine job on requester 1
        set_ops(1, 48, 18);
        req = 4'b0010;
        @(negedge clock);
        check("t1_start", 32'(eng_start), 32'd1);
        check("t1_eng_a", 32'(eng_a), 32'd48);
        check("t1_eng_b", 32'(eng_b), 32'd18);
        wait_ack("t1_ack_wait", 50, cyc);
        check("t1_latency", 32'(cyc), 32'd7);
        check("t1_ack", 32'(ack), 32'b0010);
        check("t1_result", 32'(result), 32'd6);
        req = '0;

        // all four held: grants rotate 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_ops(i, (i + 2) * 6, (i + 1) * 4);
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_ack("t2_ack_wait", 50, cyc);
            check("t2_order", 32'(ack), 32'(1 << (j % N)));
            if (j == 4) req = '0;
            @(negedge clock);
        end
        repeat (5) @(negedge clock);

        // bypass jobs on requester 2
        set_ops(2, 0, 35);
        req = 4'b0100;
        @(negedge clock);
        check("t3_no_start", 32'(eng_start), 32'd0);
        @(negedge clock);
        check("t3_ack", 32'(ack), 32'b0100);
        check("t3_result", 32'(result), 32'd35);
        check("t3_err", 32'(err), 32'd0);
        req = '0;
        repeat (3) @(negedge clock);
        set_ops(2, 0, 0);
        req = 4'b0100;
        repeat (2) @(negedge clock);
        check("t3_zero_ack", 32'(ack), 32'b0100);
        check("t3_zero_result", 32'(result), 32'd0);
        req = '0;
        repeat (5) @(negedge clock);

        // engine never finishes: abort after TO wait cycles
        eng_never = 1;
        set_ops(0, 9, 6);
        req = 4'b0001;
        @(negedge clock);
        check("t4_start", 32'(eng_start), 32'd1);
        wait_ack("t4_ack_wait", 60, cyc);
        check("t4_latency", 32'(cyc), 32'd18);
        check("t4_err", 32'(err), 32'd1);
        check("t4_result", 32'(result), 32'd0);
        check("t4_clear", 32'(eng_clear), 32'd1);
        req = '0;
        eng_never = 0;
        repeat (3) @(negedge clock);
        set_ops(1, 12, 8);
        req = 4'b0010;
        wait_ack("t4b_ack_wait", 50, cyc);
        check("t4b_err", 32'(err), 32'd0);
        check("t4b_result", 32'(result), 32'd4);
        req = '0;
        repeat (5) @(negedge clock);

        // asynchronous reset during WAIT
        eng_never = 1;
        set_ops(1, 30, 12);
        req = 4'b0010;
        wait_start("t5_start_wait", 10);
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_ack", 32'(ack), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_grant", 32'(grant_id), 32'd0);
        check("t5_rst_eng_a", 32'(eng_a), 32'd0);
        check("t5_rst_result", 32'(result), 32'd0);
        req = '0;
        eng_never = 0;
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        set_ops(0, 20, 8);
        set_ops(3, 9, 3);
        req = 4'b1001;
        @(negedge clock);
        check("t5_first_grant", 32'(grant_id), 32'd0);
        wait_ack("t5_ack_wait", 50, cyc);
        check("t5_ack", 32'(ack), 32'b0001);
        check("t5_result", 32'(result), 32'd4);
        req[0] = 1'b0;
        @(negedge clock);
        wait_ack("t5b_ack_wait", 50, cyc);
        check("t5b_ack", 32'(ack), 32'b1000);
        check("t5b_result", 32'(result), 32'd3);
        req = '0;
        repeat (5) @(negedge clock);

        // requester 3 drops req and changes operands mid-job
        eng_lat = 8;
        s0 = eng_starts;
        set_ops(3, 60, 45);
        req = 4'b1000;
        wait_start("t6_start_wait", 10);
        repeat (2) @(negedge clock);
        req[3] = 1'b0;
        set_ops(3, 7, 3);
        wait_ack("t6_ack_wait", 50, cyc);
        check("t6_ack", 32'(ack), 32'b1000);
        check("t6_result", 32'(result), 32'd15);
        repeat (4) @(negedge clock);
        check("t6_one_start", 32'(eng_starts - s0), 32'd1);

        // randomized traffic
        glitch_en = 1;
        rand_hang = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            eng_lat = $urandom_range(0, 10);
            for (int i = 0; i < N; i++) begin
                if (drop_next[i]) begin
                    req[i] = 1'b0;
                    drop_next[i] = 1'b0;
                end else if (ack[i]) begin
                    if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
                    else drop_next[i] = 1'b1;
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    set_ops(i, rnd_op(), rnd_op());
                    req[i] = 1'b1;
                end
            end
            if (busy && req[grant_id] && $urandom_range(0, 39) == 0) begin
                req[grant_id] = 1'b0;
                set_ops(int'(grant_id), $urandom_range(0, 255), $urandom_range(0, 255));
            end
        end
        req = '0;
        glitch_en = 0;
        rand_hang = 0;
        repeat (40) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
